ehgu_mc_fifo: RTL and testbench
===============================

Name: ehgu_mc_fifo

Overview:
Single-clock, multi-channel FIFO holding NCH independent queues of DEPTH words each, with one shared write port and one shared read port. Reads are granted round-robin across non-empty channels into a registered output stage with a valid/ready handshake. The block adds per-channel occupancy, almost-full, flush and sticky overflow reporting. It is the same-clock-domain successor to ehgu_fifo, used wherever several producers share one consumer.

Parameters:
NCH, 4, number of channels (>=2)
DEPTH, 16, words per channel (power of 2, >=2)
WIDTH, 8, data width
AF_THRESH, DEPTH-2, almost_full[c] is high when level[c] >= AF_THRESH
(localparams) CW = $clog2(NCH); AW = $clog2(DEPTH); LW = AW+1

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
en  in  1  global enable; 0 freezes writes and output loads
din_valid  in  1  write request
din_ch  in  CW  target channel of write
din  in  WIDTH  write data
din_ready  out  1  = !full[din_ch] && !flush[din_ch]
dout_valid  out  1  output register holds a word
dout_ready  in  1  consumer accepts the word
dout  out  WIDTH  output data
dout_ch  out  CW  channel the output word came from
flush  in  NCH  per-channel synchronous clear
clr_ovf  in  1  clears overflow
full  out  NCH  level[c] == DEPTH
empty  out  NCH  level[c] == 0
almost_full  out  NCH  level[c] >= AF_THRESH
level  out  NCH*LW  packed per-channel memory occupancy, channel 0 in LSBs
overflow  out  1  sticky: a write was dropped

Behaviour:
- Reset (async, rstn=0): all pointers 0, level=0, empty=all 1s, full/almost_full=0, dout_valid=0, dout=0, dout_ch=0, overflow=0, arbiter last-grant = NCH-1, so channel 0 has first priority.
- Storage: NCH*DEPTH register array. Per-channel wr/rd pointers are LW bits wide and wrap naturally. Full when the MSBs differ and the low AW bits are equal.
- Write: accepted at a rising edge when en && din_valid && din_ready. Full is the registered value; there is no same-cycle pop bypass.
- Overflow: en && din_valid && full[din_ch] sets overflow. The data is dropped and pointers are unchanged. clr_ovf clears overflow; a new drop in the same cycle as clr_ovf wins (overflow stays 1).
- Output stage load: load when en && (!dout_valid || dout_ready) and at least one channel is non-empty. The round-robin grant goes to the first non-empty channel after last-grant. The word moves into dout/dout_ch, the channel rd pointer advances, and last-grant updates.
- If a pop occurs and nothing is loadable, dout_valid drops to 0 next cycle. While dout_valid && !dout_ready, dout and dout_ch hold stable.
- Latency: word written at edge k into an idle block gives dout_valid=1 after edge k+1. Sustained throughput is 1 word/cycle.
- level[c] counts memory entries only, not the output register. A simultaneous write and pop on the same channel leaves level unchanged.
- flush[c]: at the next edge, wr=rd=0 for channel c, overriding any write or pop on c that cycle. If dout_valid && dout_ch==c && !dout_ready, the output word is discarded (dout_valid=0 or reloaded from another channel in the same edge).
- en=0: no writes and no loads. A pending output stays valid; dout_ready with en=0 still completes that handshake. Flush and clr_ovf act regardless of en.
- Reset mid-operation: all contents are lost immediately and outputs take reset values asynchronously.

Decomposition:
- Package ehgu_fifo_pkg: function clog2_min1 (returns >=1 for CW when NCH=1 is ever allowed), typedef for the level vector helper, and constant RR_START = NCH-1.
- Sub-module ehgu_rr_arb (NCH-wide request vector, last-grant register, one-hot and binary grant outputs, advance strobe) is reusable. The rest is one module.

Test Plan:
- Reset then write ch2 data 8'hA5 at edge 1 -> dout_valid=1, dout=A5, dout_ch=2 after edge 2; level[2] returns to 0; empty all 1s.
- Fill ch1 with 16 writes (0,3,6..45) while dout_ready=0 -> full[1]=1, almost_full[1]=1 at level 14, din_ready=0. A 17th write sets overflow=1, and data 48 is never seen. clr_ovf then overflow=0.
- Load ch0, ch1, ch3 with 2 words each, dout_ready=1 -> output channel order 0,1,3,0,1,3, one word per cycle, and data order preserved per channel.
- Backpressure: dout_ready=0 for 5 cycles with dout=7 -> dout/dout_ch stable. Release -> next word appears on the following cycle with no loss or duplication.
- flush[0] while ch0 holds 4 words and its head sits unaccepted in the output register -> next cycle level[0]=0, empty[0]=1, dout_valid=0 (or the ch2 word if ch2 is non-empty). Other channels are unchanged.
- Pulse rstn low mid-stream (async, between edges) -> dout_valid, level, overflow go to 0 immediately. The first post-reset write to ch3 emerges with 2-cycle latency.

Source files
------------

// File: rtl/ehgu_mc_fifo_pkg.sv
// Shared helpers for the ehgu FIFO family: index-width sizing and the
// arbiter start point that gives channel 0 first priority after reset.
package ehgu_fifo_pkg;

  // Keeps index fields at least one bit wide, even for a single channel.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Last-grant value loaded at reset (RR_START = NCH-1).
  function automatic int rr_start(input int nch);
    return nch - 1;
  endfunction

  // Width of one per-channel occupancy field in the packed level vector.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // One per-channel occupancy field, sized for the default DEPTH of 16.
  typedef logic [4:0] lvl_t;

endpackage

// File: rtl/ehgu_mc_fifo_if.sv
// Shared write port and registered read port of the multi-channel FIFO.
interface ehgu_mc_fifo_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8
);
  localparam int CW = ehgu_fifo_pkg::clog2_min1(NCH);

  logic             din_valid;
  logic [CW-1:0]    din_ch;
  logic [WIDTH-1:0] din;
  logic             din_ready;
  logic             dout_valid;
  logic             dout_ready;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    dout_ch;

  modport master (
    output din_valid, din_ch, din, dout_ready,
    input  din_ready, dout_valid, dout, dout_ch
  );

  modport slave (
    input  din_valid, din_ch, din, dout_ready,
    output din_ready, dout_valid, dout, dout_ch
  );
endinterface

// File: rtl/ehgu_rr_arb.sv
// Round-robin arbiter: grants the first requester after the last grant,
// and records that grant when the advance strobe fires.
module ehgu_rr_arb
  import ehgu_fifo_pkg::*;
#(
  parameter  int NCH = 4,
  localparam int CW  = clog2_min1(NCH)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [NCH-1:0] req,
  input  logic           adv,
  output logic [NCH-1:0] gnt_oh,
  output logic [CW-1:0]  gnt_bin,
  output logic           any
);

  logic [CW-1:0] last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      last <= CW'(rr_start(NCH));
    else if (adv && any)
      last <= gnt_bin;
  end

  always_comb begin
    int idx;
    gnt_oh  = '0;
    gnt_bin = '0;
    any     = 1'b0;
    idx     = 0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(last) + i) % NCH;
      if (!any && req[idx]) begin
        any         = 1'b1;
        gnt_oh[idx] = 1'b1;
        gnt_bin     = CW'(idx);
      end
    end
  end

endmodule

// File: rtl/ehgu_mc_fifo.sv
// NCH independent queues behind one write port, drained round-robin into a
// single registered valid/ready output stage.
module ehgu_mc_fifo
  import ehgu_fifo_pkg::*;
#(
  parameter  int NCH       = 4,
  parameter  int DEPTH     = 16,
  parameter  int WIDTH     = 8,
  parameter  int AF_THRESH = DEPTH - 2,
  localparam int CW        = clog2_min1(NCH),
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [NCH-1:0]    flush,
  input  logic              clr_ovf,
  ehgu_mc_fifo_if.slave     bus,
  output logic [NCH-1:0]    full,
  output logic [NCH-1:0]    empty,
  output logic [NCH-1:0]    almost_full,
  output logic [NCH*LW-1:0] level,
  output logic              overflow
);

  localparam logic [LW-1:0] AF_L = LW'(AF_THRESH);

  logic [WIDTH-1:0] mem [NCH][DEPTH];
  logic [LW-1:0]    wr_ptr [NCH];
  logic [LW-1:0]    rd_ptr [NCH];
  logic [LW-1:0]    lvl    [NCH];

  logic [NCH-1:0]   req, gnt_oh;
  logic [CW-1:0]    gnt;
  logic             any;
  logic             wr_en, ovf_set, out_free, ld;

  logic [WIDTH-1:0] dout_p1;
  logic [CW-1:0]    ch_p1;
  logic             vld_p1;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign lvl[c]              = wr_ptr[c] - rd_ptr[c];
    assign full[c]             = (wr_ptr[c][AW] != rd_ptr[c][AW]) &&
                                 (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
    assign empty[c]            = (wr_ptr[c] == rd_ptr[c]);
    assign almost_full[c]      = (lvl[c] >= AF_L);
    assign level[c*LW +: LW]   = lvl[c];
    // A channel being flushed this edge must not feed the output stage.
    assign req[c]              = !empty[c] && !flush[c];
  end

  assign bus.din_ready = !full[bus.din_ch] && !flush[bus.din_ch];
  assign wr_en         = en && bus.din_valid && bus.din_ready;
  assign ovf_set       = en && bus.din_valid && full[bus.din_ch];
  // Output slot frees on accept, when empty, or when its word is flushed.
  assign out_free      = !vld_p1 || bus.dout_ready || flush[ch_p1];
  assign ld            = en && out_free && any;

  ehgu_rr_arb #(.NCH(NCH)) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req),
    .adv     (ld),
    .gnt_oh  (gnt_oh),
    .gnt_bin (gnt),
    .any     (any)
  );

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[bus.din_ch][wr_ptr[bus.din_ch][AW-1:0]] <= bus.din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (flush[c]) begin
          wr_ptr[c] <= '0;
          rd_ptr[c] <= '0;
        end else begin
          if (wr_en && (bus.din_ch == CW'(c)))
            wr_ptr[c] <= wr_ptr[c] + LW'(1);
          if (ld && gnt_oh[c])
            rd_ptr[c] <= rd_ptr[c] + LW'(1);
        end
      end
    end
  end

  // p1: registered output stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1  <= 1'b0;
      dout_p1 <= '0;
      ch_p1   <= '0;
    end else if (ld) begin
      vld_p1  <= 1'b1;
      dout_p1 <= mem[gnt][rd_ptr[gnt][AW-1:0]];
      ch_p1   <= gnt;
    end else if (out_free) begin
      vld_p1  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      overflow <= 1'b0;
    else if (ovf_set)
      overflow <= 1'b1;
    else if (clr_ovf)
      overflow <= 1'b0;
  end

  assign bus.dout_valid = vld_p1;
  assign bus.dout       = dout_p1;
  assign bus.dout_ch    = ch_p1;

endmodule

// File: tb/tb_ehgu_mc_fifo.sv
// Directed bench for ehgu_mc_fifo with hand-computed expectations.
module tb_ehgu_mc_fifo;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [3:0]  flush;
  logic        clr_ovf;
  logic [3:0]  full, empty, almost_full;
  logic [19:0] level;
  logic        overflow;

  int n_chk = 0;
  int n_err = 0;

  ehgu_mc_fifo_if #(.NCH(4), .WIDTH(8)) bus ();

  ehgu_mc_fifo #(.NCH(4), .DEPTH(16), .WIDTH(8), .AF_THRESH(14)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .en          (en),
    .flush       (flush),
    .clr_ovf     (clr_ovf),
    .bus         (bus),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .level       (level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] lv(input int c);
    return level[c*5 +: 5];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int d);
    bus.din_valid = 1'b1;
    bus.din_ch    = 2'(ch);
    bus.din       = 8'(d);
    tick();
    bus.din_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int d, input int ch);
    check({tag, "_vld"}, 32'(bus.dout_valid), 32'd1);
    check({tag, "_dat"}, 32'(bus.dout), 32'(d));
    check({tag, "_ch"},  32'(bus.dout_ch), 32'(ch));
  endtask

  initial begin
    rstn           = 1'b0;
    en             = 1'b1;
    flush          = '0;
    clr_ovf        = 1'b0;
    bus.din_valid  = 1'b0;
    bus.din_ch     = '0;
    bus.din        = '0;
    bus.dout_ready = 1'b0;
    #2;
    check("rst_vld",   32'(bus.dout_valid), 32'd0);
    check("rst_dout",  32'(bus.dout), 32'd0);
    check("rst_ch",    32'(bus.dout_ch), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'hF);
    check("rst_full",  32'(full), 32'd0);
    check("rst_af",    32'(almost_full), 32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);
    tick();
    rstn = 1'b1;

    // Single word, two-edge latency
    wr(2, 8'hA5);
    check("t1_lvl2",  32'(lv(2)), 32'd1);
    check("t1_empty", 32'(empty), 32'hB);
    check("t1_vld0",  32'(bus.dout_valid), 32'd0);
    tick();
    chk_out("t1_out", 8'hA5, 2);
    check("t1_lvl2b", 32'(lv(2)), 32'd0);
    check("t1_emptyb", 32'(empty), 32'hF);
    bus.dout_ready = 1'b1;
    tick();
    check("t1_drain", 32'(bus.dout_valid), 32'd0);
    bus.dout_ready = 1'b0;

    // Fill ch1 behind a stalled ch0 word, then overflow
    wr(0, 8'h11);
    tick();
    chk_out("t2_hold", 8'h11, 0);
    for (int i = 0; i < 16; i++) begin
      wr(1, 3 * i);
      if (i == 12) check("t2_af_lo", 32'(almost_full[1]), 32'd0);
      if (i == 13) begin
        check("t2_af_hi",  32'(almost_full[1]), 32'd1);
        check("t2_lvl14",  32'(lv(1)), 32'd14);
      end
    end
    check("t2_full",  32'(full), 32'h2);
    check("t2_lvl16", 32'(lv(1)), 32'd16);
    bus.din_ch = 2'd1;
    #1;
    check("t2_rdy",   32'(bus.din_ready), 32'd0);
    check("t2_ovf0",  32'(overflow), 32'd0);
    bus.din_valid = 1'b1;
    bus.din       = 8'd48;
    tick();
    check("t2_ovf1",  32'(overflow), 32'd1);
    check("t2_lvlk",  32'(lv(1)), 32'd16);
    clr_ovf = 1'b1;
    tick();
    check("t2_ovf_win", 32'(overflow), 32'd1);
    bus.din_valid = 1'b0;
    tick();
    clr_ovf = 1'b0;
    check("t2_ovf_clr", 32'(overflow), 32'd0);
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_out($sformatf("t2_d%0d", i), 3 * i, 1);
    end
    tick();
    check("t2_no48", 32'(bus.dout_valid), 32'd0);
    bus.dout_ready = 1'b0;

    // Round-robin order 0,1,3,0,1,3
    wr(0, 8'h10); wr(1, 8'h20); wr(3, 8'h30);
    wr(0, 8'h11); wr(1, 8'h21); wr(3, 8'h31);
    chk_out("t3_o0", 8'h10, 0);
    bus.dout_ready = 1'b1;
    tick(); chk_out("t3_o1", 8'h20, 1);
    tick(); chk_out("t3_o2", 8'h30, 3);
    tick(); chk_out("t3_o3", 8'h11, 0);
    tick(); chk_out("t3_o4", 8'h21, 1);
    tick(); chk_out("t3_o5", 8'h31, 3);
    tick(); check("t3_end", 32'(bus.dout_valid), 32'd0);
    bus.dout_ready = 1'b0;

    // Backpressure holds the output stable
    wr(2, 7);
    wr(2, 8);
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("t4_hold%0d", i), 7, 2);
      tick();
    end
    bus.dout_ready = 1'b1;
    tick(); chk_out("t4_next", 8, 2);
    tick(); check("t4_end", 32'(bus.dout_valid), 32'd0);
    bus.dout_ready = 1'b0;

    // Flush ch0 while its head is stalled in the output register
    wr(0, 8'h40); wr(0, 8'h41); wr(0, 8'h42); wr(0, 8'h43); wr(0, 8'h44);
    wr(2, 8'h50); wr(3, 8'h60);
    check("t5_lvl0", 32'(lv(0)), 32'd4);
    chk_out("t5_head", 8'h40, 0);
    flush = 4'b0001;
    tick();
    flush = '0;
    check("t5_lvl0f",  32'(lv(0)), 32'd0);
    check("t5_empty",  32'(empty), 32'h7);
    check("t5_lvl3",   32'(lv(3)), 32'd1);
    chk_out("t5_reload", 8'h50, 2);
    bus.dout_ready = 1'b1;
    tick(); chk_out("t5_ch3", 8'h60, 3);
    tick(); check("t5_end", 32'(bus.dout_valid), 32'd0);
    bus.dout_ready = 1'b0;

    // en=0 blocks writes
    en = 1'b0;
    wr(1, 8'h77);
    check("t6_noen", 32'(lv(1)), 32'd0);
    en = 1'b1;

    // Asynchronous reset mid-stream
    wr(1, 8'h71);
    wr(1, 8'h72);
    check("t7_pre", 32'(bus.dout_valid), 32'd1);
    #3;
    rstn = 1'b0;
    #1;
    check("t7_vld",   32'(bus.dout_valid), 32'd0);
    check("t7_level", 32'(level), 32'd0);
    check("t7_empty", 32'(empty), 32'hF);
    check("t7_ovf",   32'(overflow), 32'd0);
    #2;
    rstn = 1'b1;
    wr(3, 8'h99);
    check("t7_lat1", 32'(bus.dout_valid), 32'd0);
    tick();
    chk_out("t7_lat2", 8'h99, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
